// File: rtl/stage_pkg.sv
// Shared stage numbering, instruction classes and opcode map for the
// multicycle stage-timing consumer.
package stage_pkg;

  localparam logic [2:0] ST_IF  = 3'd0;
  localparam logic [2:0] ST_ID  = 3'd1;
  localparam logic [2:0] ST_EX  = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3;
  localparam logic [2:0] ST_WB  = 3'd4;

  typedef enum logic [2:0] {
    CL_NOP    = 3'd0,
    CL_ALU    = 3'd1,
    CL_LOAD   = 3'd2,
    CL_STORE  = 3'd3,
    CL_BRANCH = 3'd4,
    CL_HALT   = 3'd5
  } class_e;

  localparam logic [3:0] OPC_NOP    = 4'h0;
  localparam logic [3:0] OPC_ALU    = 4'h1;
  localparam logic [3:0] OPC_LOAD   = 4'h2;
  localparam logic [3:0] OPC_STORE  = 4'h3;
  localparam logic [3:0] OPC_BRANCH = 4'h4;
  localparam logic [3:0] OPC_HALT   = 4'h5;

  function automatic logic [2:0] final_stage(input class_e cls);
    case (cls)
      CL_NOP:    final_stage = ST_ID;
      CL_BRANCH: final_stage = ST_EX;
      CL_ALU:    final_stage = ST_MEM;
      CL_STORE:  final_stage = ST_MEM;
      CL_LOAD:   final_stage = ST_WB;
      CL_HALT:   final_stage = ST_ID;
      default:   final_stage = ST_ID;
    endcase
  endfunction

endpackage

// File: rtl/stage_decoder_if.sv
// Stage-timing bus between the timing generator (master) and the
// stage decoder (slave).
interface stage_decoder_if #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned RET_W = 16
);
  logic [2:0]       Cnt;
  logic [OP_W-1:0]  Opcode;
  logic             LastStage;
  logic             IrWrite;
  logic             RegRead;
  logic             AluEn;
  logic             MemRd;
  logic             MemWr;
  logic             RegWr;
  logic             PcWr;
  logic             Halted;
  logic             Err;
  logic [RET_W-1:0] Retired;

  modport master (
    output Cnt, Opcode,
    input  LastStage, IrWrite, RegRead, AluEn, MemRd, MemWr, RegWr, PcWr,
           Halted, Err, Retired
  );

  modport slave (
    input  Cnt, Opcode,
    output LastStage, IrWrite, RegRead, AluEn, MemRd, MemWr, RegWr, PcWr,
           Halted, Err, Retired
  );
endinterface

// File: rtl/stage_decoder_seq_monitor.sv
// Checks that the stage count advances by one per cycle and restarts at
// IF after each final stage; also latches illegal-opcode events.
module stage_seq_monitor
  import stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cnt,
  input  logic       last,
  input  logic       enable,
  input  logic       illegal,
  output logic       err
);

  logic [2:0] prev_cnt_q;
  logic       last_q;
  logic       violation;

  // Judged against the previous cycle's count/LastStage before they update.
  always_comb begin
    violation = 1'b0;
    if (cnt > ST_WB)
      violation = 1'b1;
    else if (last_q)
      violation = (cnt != ST_IF);
    else
      violation = (cnt != prev_cnt_q + 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cnt_q <= ST_IF;
      last_q     <= 1'b1;
      err        <= 1'b0;
    end else begin
      if (enable) begin
        if (violation)
          err <= 1'b1;
        prev_cnt_q <= cnt;
        last_q     <= last;
      end
      if (illegal)
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/stage_decoder.sv
// Latches the instruction class at fetch and turns the stage count into
// per-stage control enables, retire count, halt and protocol error.
module stage_decoder #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned RET_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  stage_decoder_if.slave bus
);
  import stage_pkg::*;

  class_e           cls_q;
  class_e           cls_dec;
  logic             illegal_op;
  logic             halted_q;
  logic [RET_W-1:0] retired_q;
  logic             last;
  logic             run;
  logic             capture;
  logic             err;

  always_comb begin
    cls_dec    = CL_NOP;
    illegal_op = 1'b0;
    case (bus.Opcode)
      OP_W'(OPC_NOP):    cls_dec = CL_NOP;
      OP_W'(OPC_ALU):    cls_dec = CL_ALU;
      OP_W'(OPC_LOAD):   cls_dec = CL_LOAD;
      OP_W'(OPC_STORE):  cls_dec = CL_STORE;
      OP_W'(OPC_BRANCH): cls_dec = CL_BRANCH;
      OP_W'(OPC_HALT):   cls_dec = CL_HALT;
      default:           illegal_op = 1'b1;
    endcase
  end

  // LastStage is deliberately not gated by reset; the enables are.
  assign last    = !halted_q && (bus.Cnt == final_stage(cls_q));
  assign run     = rst_n && !halted_q;
  assign capture = (bus.Cnt == ST_IF) && !halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q     <= CL_NOP;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if (capture)
        cls_q <= cls_dec;
      if (last) begin
        retired_q <= retired_q + RET_W'(1);
        if (cls_q == CL_HALT)
          halted_q <= 1'b1;
      end
    end
  end

  stage_seq_monitor u_mon (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt     (bus.Cnt),
    .last    (last),
    .enable  (!halted_q),
    .illegal (capture && illegal_op),
    .err     (err)
  );

  assign bus.LastStage = last;
  assign bus.IrWrite   = run && (bus.Cnt == ST_IF);
  assign bus.RegRead   = run && (bus.Cnt == ST_ID);
  assign bus.AluEn     = run && (bus.Cnt == ST_EX);
  assign bus.MemRd     = run && (bus.Cnt == ST_MEM) && (cls_q == CL_LOAD);
  assign bus.MemWr     = run && (bus.Cnt == ST_MEM) && (cls_q == CL_STORE);
  assign bus.RegWr     = run && (((bus.Cnt == ST_MEM) && (cls_q == CL_ALU)) ||
                                 ((bus.Cnt == ST_WB)  && (cls_q == CL_LOAD)));
  assign bus.PcWr      = run && ((bus.Cnt == ST_IF) ||
                                 ((bus.Cnt == ST_EX) && (cls_q == CL_BRANCH)));
  assign bus.Halted    = halted_q;
  assign bus.Err       = err;
  assign bus.Retired   = retired_q;

endmodule

// File: doc/stage_decoder.md
Name: stage_decoder

Overview:
- Consumer end of the multicycle RISC stage-timing interface. Reads the 3-bit stage count `Cnt` from the timing generator.
- Latches the instruction class at fetch and drives per-stage control enables.
- Returns `LastStage` to the timing generator so it restarts at stage 0.
- Also tracks retired instructions, halt, and protocol errors (illegal opcode, illegal stage sequence).

Parameters:
- OP_W, 4, opcode field width.
- RET_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Cnt  input  3  current stage from the timing generator: 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB.
- Opcode  input  OP_W  opcode field of the memory word; sampled only while Cnt==0.
- LastStage  output  1  combinational; high during the final stage of the current instruction.
- IrWrite  output  1  high when Cnt==0 and not halted.
- RegRead  output  1  high when Cnt==1.
- AluEn  output  1  high when Cnt==2.
- MemRd  output  1  high when Cnt==3 and class==LOAD.
- MemWr  output  1  high when Cnt==3 and class==STORE.
- RegWr  output  1  high on (Cnt==3 and class==ALU) or (Cnt==4 and class==LOAD).
- PcWr  output  1  high on (Cnt==0 and not halted) or (Cnt==2 and class==BRANCH).
- Halted  output  1  sticky; set by the HALT class.
- Err  output  1  sticky protocol error.
- Retired  output  RET_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n low):
  - class_q=NOP, halted=0, Err=0, Retired=0, prev_cnt_q=0, last_q=1.
  - The first valid Cnt is therefore 0.
  - Every output listed above is 0 while in reset, except LastStage, which follows its combinational rule with class NOP.
- Class capture:
  - On each clock edge with Cnt==0 and !halted, class_q <= decode(Opcode).
  - Opcodes outside the class table decode to NOP and set Err.
- Class table and final stage:
  - NOP: final stage 1.
  - BRANCH: final stage 2.
  - ALU: final stage 3.
  - STORE: final stage 3.
  - LOAD: final stage 4.
  - HALT: final stage 1; also sets halted at that edge.
- LastStage = !halted and Cnt == final_stage(class_q).
  - It is never asserted at Cnt==0; class_q is stale during IF.
- Retire: each edge with LastStage=1 increments Retired.
  - Wraps at 2^RET_W-1 to 0; no saturation.
- Sequence monitor. Each edge, with prev_cnt_q/last_q holding the previous cycle's Cnt/LastStage, Err is set if:
  - last_q=1 and Cnt!=0; or
  - last_q=0 and Cnt!=prev_cnt_q+1; or
  - Cnt>4 at any time.
  - Check order per edge: compute the violation from the old prev_cnt_q/last_q, then update both.
- Halt:
  - Once halted, all enables and LastStage are 0.
  - Retired freezes; class_q freezes.
  - The sequence monitor is disabled.
  - Only rst_n clears halted.
- Err is informational. Control enables keep operating after Err is set.
- Simultaneous events: the HALT final edge both increments Retired and sets halted.
- Reset mid-instruction discards class_q. The next Cnt must be 0, otherwise Err.

Decomposition:
- Package stage_pkg holds:
  - Stage constants ST_IF..ST_WB.
  - Class enum CL_NOP, CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_HALT, as 3-bit localparams.
  - Opcode encodings.
  - The final_stage function.
- One sub-module, stage_seq_monitor, contains prev_cnt_q, last_q and the Err logic.
- Decode, enables and counters stay in the top module.

Test Plan:
- ALU opcode: drive Cnt 0,1,2,3 -> IrWrite@0, RegRead@1, AluEn@2, RegWr+LastStage@3; Retired 0->1; Err=0.
- LOAD then STORE back-to-back:
  - LOAD Cnt 0..4 -> MemRd@3, RegWr+LastStage@4.
  - STORE Cnt 0..3 -> MemWr@3, LastStage@3.
  - Retired=2 at the end.
- BRANCH: Cnt 0,1,2 -> PcWr@0 and @2, LastStage@2; next Cnt=0 accepted with Err=0.
- Sequence violation:
  - ALU instruction with Cnt 0,1,3 -> Err=1 after the edge at Cnt=3.
  - Separately: LastStage at Cnt=3, then Cnt=4 -> Err=1.
- HALT: Cnt 0,1 -> LastStage@1, Retired+1, Halted=1. Further Cnt=0 leaves IrWrite/PcWr/LastStage at 0 and Retired frozen. rst_n low clears Halted=0, Retired=0.
- Reset mid-LOAD at Cnt=2 -> outputs 0. After release, Cnt=0 gives Err=0; Cnt=3 instead gives Err=1. Retired wrap: preload to 0xFFFF, retire one -> 0x0000.
